dcache_wb_dm: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the single-cycle core's D-port and a slow block-wide data memory.
- Core side keeps the word interface, plus a stall the core uses to freeze PC and register writes.
- Memory side moves 4-word (128-bit) blocks through a req/ready handshake with multi-cycle latency.
- Data is byte-order transparent; the core already does any endianness swap.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_array.sv | 64 ++++++
 rtl/dcache_wb_dm.sv | 137 +++++++++++++
 tb/tb_dcache_wb_dm.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants, state encoding and word-select helper for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W          = 30;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
  localparam int OFFSET_W        = 2;
  localparam int MEM_ADDR_W      = ADDR_W - OFFSET_W;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE      = 2'd0;
  localparam state_t S_WRITEBACK = 2'd1;
  localparam state_t S_ALLOCATE  = 2'd2;

  // Pick one word out of a block; word0 sits in the low bits.
  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0]  blk,
                                                 input logic [OFFSET_W-1:0] off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for the cache, all in flops.
// Read port is combinational on idx_i; a fill replaces a whole block and
// marks it clean, a word write updates one word and marks it dirty.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  idx_i,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [BLOCK_W-1:0]  block_o,
  input  logic                fill_i,
  input  logic [TAG_W-1:0]    fill_tag_i,
  input  logic [BLOCK_W-1:0]  fill_data_i,
  input  logic                wr_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [WORD_W-1:0]   wr_data_i
);

  localparam int NUM_BLOCKS = 1 << INDEX_W;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  // Combinational read of the indexed line.
  always_comb begin
    valid_o = valid_q[idx_i];
    dirty_o = dirty_q[idx_i];
    tag_o   = tag_q[idx_i];
    block_o = data_q[idx_i];
  end

  // Line update: fill from memory or merge one store word.
  // NOTE: tag and data are reset along with valid/dirty so that victim
  // contents and mem_wdata are deterministic; this only works because the
  // storage is flops, not an SRAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_i) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
      tag_q[idx_i]   <= fill_tag_i;
      data_q[idx_i]  <= fill_data_i;
    end else if (wr_i) begin
      dirty_q[idx_i]                          <= 1'b1;
      data_q[idx_i][wr_off_i*WORD_W +: WORD_W] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache.
// Core side: word interface with a stall. Memory side: 128-bit block
// transfers with a req/ready handshake (mem_ready is a one-cycle pulse).
// Optional build macro DCACHE_PERF_EN adds hit_cnt/miss_cnt outputs.
module dcache_wb_dm
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25   // must equal 30 - 2 - INDEX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic [31:0]   proc_rdata,
  output logic          proc_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  state_t state_q, state_d;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    req_tag;
  logic [OFFSET_W-1:0] off;
  logic                req;
  logic                hit;

  logic                line_valid, line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_block;
  logic                fill, word_wr;

  assign idx     = proc_addr[INDEX_W+1:2];
  assign req_tag = proc_addr[ADDR_W-1:INDEX_W+2];
  assign off     = proc_addr[1:0];
  assign req     = proc_read | proc_write;
  assign hit     = line_valid && (line_tag == req_tag);

  // A fill completes ALLOCATE; a store word is merged only on an idle hit.
  // Read+write together is treated as a write.
  assign fill    = (state_q == S_ALLOCATE) && mem_ready;
  assign word_wr = (state_q == S_IDLE) && proc_write && hit;

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_i       (idx),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .block_o     (line_block),
    .fill_i      (fill),
    .fill_tag_i  (req_tag),
    .fill_data_i (mem_rdata),
    .wr_i        (word_wr),
    .wr_off_i    (off),
    .wr_data_i   (proc_wdata)
  );

  // State register; reset abandons any in-flight memory transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a miss evicts a dirty victim first, then fetches.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (req && !hit) state_d = (line_valid && line_dirty) ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: if (mem_ready)   state_d = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ready)   state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Outputs: memory side decoded from state only; core side from hit.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    proc_stall = (state_q != S_IDLE) || (req && !hit);
    proc_rdata = hit ? get_word(line_block, off) : '0;
    unique case (state_q)
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {line_tag, idx};
        mem_wdata = line_block;
      end
      S_ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = {req_tag, idx};
      end
      default: ;
    endcase
  end

`ifdef DCACHE_PERF_EN
  logic        post_fill_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Event counters; the hit that follows a fill belongs to the miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_fill_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      post_fill_q <= fill;
      if (req && !proc_stall && !post_fill_q)       hit_cnt_q  <= hit_cnt_q + 32'd1;
      if ((state_q == S_IDLE) && req && !hit)       miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Self-checking bench for dcache_wb_dm: directed sequences for misses,
// write-back, reset and spurious ready, plus a table of hit vectors.
module tb_dcache_wb_dm;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          proc_read, proc_write;
  logic [29:0]   proc_addr;
  logic [31:0]   proc_wdata;
  logic [31:0]   proc_rdata;
  logic          proc_stall;
  logic          mem_read, mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
`ifdef DCACHE_PERF_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dcache_wb_dm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  // Pulses mem_ready in the Nth cycle a request is held and logs it.
  int            lat_rd = 2;
  int            lat_wb = 2;
  int            busy_cnt;
  int            txn_n;
  int            both_high;
  logic          spurious = 1'b0;
  logic          txn_wr    [8];
  logic [27:0]   txn_addr  [8];
  logic [127:0]  txn_wdata [8];

  initial begin : mem_model
    mem_ready = 1'b0;
    busy_cnt  = 0;
    txn_n     = 0;
    both_high = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (!rst_n) begin
        busy_cnt = 0;
      end else if (mem_read || mem_write) begin
        if (mem_read && mem_write) both_high++;
        busy_cnt++;
        if (busy_cnt >= (mem_write ? lat_wb : lat_rd)) begin
          if (txn_n < 8) begin
            txn_wr[txn_n]    = mem_write;
            txn_addr[txn_n]  = mem_addr;
            txn_wdata[txn_n] = mem_wdata;
          end
          txn_n++;
          busy_cnt  = 0;
          mem_ready = 1'b1;
        end
      end else if (spurious) begin
        mem_ready = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = d;
  endtask

  // Counts stall cycles from the current (request) cycle; returns at the
  // negedge of the cycle in which proc_stall is finally low.
  task automatic wait_done(input int budget, output int stalls);
    stalls = 0;
    @(negedge clk);
    while (proc_stall && stalls < budget) begin
      stalls++;
      tick();
      @(negedge clk);
    end
    if (proc_stall) begin
      n_checks++;
      n_errors++;
      $display("FAIL stall_timeout: still stalled after %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam logic [127:0] BLK0 = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [127:0] BLK1 = {32'h13131313, 32'h12121212, 32'h11111111, 32'h10101010};
  localparam logic [127:0] BLK2 = {32'h23232323, 32'h22222222, 32'h21212121, 32'h20202020};
  localparam logic [127:0] BLK3 = {32'h33333333, 32'h32323232, 32'h31313131, 32'h30303030};

  vec_t vecs[8];
  int   stalls;
  int   base;

  initial begin : main
    // Hit vectors on the line at index 4 after the cold fill with BLK0.
    // A write row sees the old word; the store lands at the clock edge.
    vecs[0] = '{1'b1, 1'b0, 30'h13, 32'h0,        1'b0, 32'hDDDDDDDD};
    vecs[1] = '{1'b1, 1'b0, 30'h10, 32'h0,        1'b0, 32'hAAAAAAAA};
    vecs[2] = '{1'b0, 1'b1, 30'h13, 32'h11112222, 1'b0, 32'hDDDDDDDD};
    vecs[3] = '{1'b1, 1'b0, 30'h13, 32'h0,        1'b0, 32'h11112222};
    vecs[4] = '{1'b1, 1'b1, 30'h12, 32'hDEADBEEF, 1'b0, 32'hCCCCCCCC};
    vecs[5] = '{1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b0, 30'h00, 32'h0,        1'b0, 32'h00000000};
    vecs[7] = '{1'b0, 1'b0, 30'h11, 32'h0,        1'b0, 32'hBBBBBBBB};

    rst_n     = 1'b0;
    mem_rdata = '0;
    apply(1'b0, 1'b0, 30'h0, 32'h0);

    // Reset state
    @(negedge clk);
    check("rst_stall",     proc_stall, 1'b0);
    check("rst_mem_read",  mem_read,   1'b0);
    check("rst_mem_write", mem_write,  1'b0);
    check("rst_mem_addr",  mem_addr,   28'h0);
    check("rst_mem_wdata", mem_wdata,  128'h0);
    check("rst_rdata",     proc_rdata, 32'h0);
`ifdef DCACHE_PERF_EN
    check("rst_hit_cnt",   hit_cnt,    32'h0);
    check("rst_miss_cnt",  miss_cnt,   32'h0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Cold read miss, ready in the 4th cycle of mem_read -> 5 stall cycles
    base      = txn_n;
    lat_rd    = 4;
    mem_rdata = BLK0;
    apply(1'b1, 1'b0, 30'h10, 32'h0);
    wait_done(50, stalls);
    check("cold_stalls",   stalls,     5);
    check("cold_rdata",    proc_rdata, 32'hAAAAAAAA);
    check("cold_txn_cnt",  txn_n - base, 1);
    check("cold_txn_wr",   txn_wr[base],   1'b0);
    check("cold_txn_addr", txn_addr[base], 28'h0000004);
    check("cold_mem_read_dropped", mem_read, 1'b0);

    // Read hit after fill
    tick();
    apply(1'b1, 1'b0, 30'h11, 32'h0);
    @(negedge clk);
    check("hit_stall",    proc_stall, 1'b0);
    check("hit_rdata",    proc_rdata, 32'hBBBBBBBB);
    check("hit_mem_read", mem_read,   1'b0);
`ifdef DCACHE_PERF_EN
    tick();
    apply(1'b0, 1'b0, 30'h11, 32'h0);
    @(negedge clk);
    check("perf_hit_cnt",  hit_cnt,  32'd1);
    check("perf_miss_cnt", miss_cnt, 32'd1);
`endif

    // Table of hit / idle vectors
    base = txn_n;
    for (int i = 0; i < 8; i++) begin
      tick();
      apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), proc_stall, vecs[i].exp_stall);
      check($sformatf("vec%0d_rdata", i), proc_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_mem",   i), {mem_read, mem_write}, 2'b00);
    end
    tick();
    apply(1'b0, 1'b0, 30'h0, 32'h0);
    check("vec_no_txn", txn_n - base, 0);

    // Dirty conflict miss: write-back (3) then allocate (2) -> 6 stalls
    tick();
    base      = txn_n;
    lat_wb    = 3;
    lat_rd    = 2;
    mem_rdata = BLK1;
    apply(1'b1, 1'b0, 30'h92, 32'h0);
    wait_done(50, stalls);
    check("dirty_stalls",  stalls,     6);
    check("dirty_rdata",   proc_rdata, 32'h12121212);
    check("dirty_txn_cnt", txn_n - base, 2);
    check("wb_is_write",   txn_wr[base],    1'b1);
    check("wb_addr",       txn_addr[base],  28'h0000004);
    check("wb_word2",      txn_wdata[base][95:64], 32'hDEADBEEF);
    check("wb_block",      txn_wdata[base],
          {32'h11112222, 32'hDEADBEEF, 32'hBBBBBBBB, 32'hAAAAAAAA});
    check("alloc_is_read", txn_wr[base+1],   1'b0);
    check("alloc_addr",    txn_addr[base+1], 28'h0000024);

    // Clean write miss: allocate then merge the store
    tick();
    base      = txn_n;
    lat_rd    = 2;
    mem_rdata = BLK2;
    apply(1'b0, 1'b1, 30'h20, 32'h12345678);
    wait_done(50, stalls);
    check("wmiss_stalls",    stalls,         3);
    check("wmiss_txn_cnt",   txn_n - base,   1);
    check("wmiss_txn_wr",    txn_wr[base],   1'b0);
    check("wmiss_txn_addr",  txn_addr[base], 28'h0000008);
    tick();
    apply(1'b1, 1'b0, 30'h20, 32'h0);
    @(negedge clk);
    check("wmiss_merged",    proc_rdata, 32'h12345678);
    check("wmiss_hit_stall", proc_stall, 1'b0);
    tick();
    apply(1'b1, 1'b0, 30'h21, 32'h0);
    @(negedge clk);
    check("wmiss_neighbor",  proc_rdata, 32'h21212121);

    // The merged line must be dirty: evicting it writes it back
    tick();
    base      = txn_n;
    lat_wb    = 1;
    lat_rd    = 1;
    mem_rdata = BLK0;
    apply(1'b1, 1'b0, 30'h00, 32'h0);
    wait_done(50, stalls);
    check("evict_stalls",  stalls, 3);
    check("evict_txn_cnt", txn_n - base, 2);
    check("evict_wr",      txn_wr[base],    1'b1);
    check("evict_addr",    txn_addr[base],  28'h0000008);
    check("evict_wdata",   txn_wdata[base],
          {32'h23232323, 32'h22222222, 32'h21212121, 32'h12345678});
    check("evict_rdata",   proc_rdata, 32'hAAAAAAAA);

    // mem_ready while idle is ignored
    tick();
    base = txn_n;
    apply(1'b0, 1'b0, 30'h0, 32'h0);
    spurious = 1'b1;
    tick();
    tick();
    spurious = 1'b0;
    tick();
    @(negedge clk);
    check("spur_stall", proc_stall, 1'b0);
    check("spur_mem",   {mem_read, mem_write}, 2'b00);
    tick();
    apply(1'b1, 1'b0, 30'h00, 32'h0);
    @(negedge clk);
    check("spur_hit_after", {proc_stall, proc_rdata}, {1'b0, 32'hAAAAAAAA});

    // Reset in the middle of ALLOCATE
    tick();
    lat_rd    = 1000;
    mem_rdata = BLK3;
    apply(1'b1, 1'b0, 30'h50, 32'h0);
    repeat (3) tick();
    @(negedge clk);
    check("pre_rst_mem_read", mem_read, 1'b1);
    check("pre_rst_mem_addr", mem_addr, 28'h0000014);
    rst_n = 1'b0;
    #1;
    check("rst_drop_mem_read", mem_read, 1'b0);
    check("rst_drop_mem_addr", mem_addr, 28'h0);
    apply(1'b0, 1'b0, 30'h50, 32'h0);
    #1;
    check("rst_drop_stall", proc_stall, 1'b0);
    check("rst_drop_rdata", proc_rdata, 32'h0);
    tick();
    rst_n  = 1'b1;
    lat_rd = 2;
    tick();
    base = txn_n;
    apply(1'b1, 1'b0, 30'h50, 32'h0);
    wait_done(50, stalls);
    check("post_rst_stalls",  stalls, 3);
    check("post_rst_txn_cnt", txn_n - base, 1);
    check("post_rst_txn_wr",  txn_wr[base],   1'b0);
    check("post_rst_addr",    txn_addr[base], 28'h0000014);
    check("post_rst_rdata",   proc_rdata, 32'h30303030);

    tick();
    apply(1'b0, 1'b0, 30'h0, 32'h0);
    check("never_both_high", both_high, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
